// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus per-bit stability-counter debouncer for board slide switches.
// Debounced value feeds the I/O read mux; sticky per-bit change flags support software polling.
module switch_debouncer #(
   parameter int WIDTH        = 8,
   parameter int CNT_BITS     = 20,
   parameter int STABLE_COUNT = 500000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] switches_raw,
   input  logic             clear,
   output logic [WIDTH-1:0] switches,
   output logic [WIDTH-1:0] changed,
   output logic             any_changed
);

   // Per-bit debounce FSM, state implied by r_sync2[i] vs r_stable[i]:
   //   state   | meaning
   //   IDLE    | sync2 == stable, counter held at 0
   //   PENDING | sync2 != stable, counting toward commit at STABLE_COUNT-1

   localparam logic [CNT_BITS-1:0] LP_TC = CNT_BITS'(STABLE_COUNT - 1);

   logic [WIDTH-1:0]    r_sync1;
   logic [WIDTH-1:0]    r_sync2;
   logic [WIDTH-1:0]    r_stable;
   logic [WIDTH-1:0]    r_changed;
   logic                r_any_changed;
   logic [CNT_BITS-1:0] r_cnt [WIDTH];

   logic [CNT_BITS-1:0] w_cnt_nxt [WIDTH];
   logic [WIDTH-1:0]    w_stable_nxt;
   logic [WIDTH-1:0]    w_commit;
   logic [WIDTH-1:0]    w_changed_nxt;

   always_comb begin
      w_stable_nxt = r_stable;
      w_commit     = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_cnt_nxt[i] = '0;
         if (r_sync2[i] != r_stable[i]) begin
            if (r_cnt[i] == LP_TC) begin
               w_stable_nxt[i] = r_sync2[i];
               w_commit[i]     = 1'b1;
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + CNT_BITS'(1);
            end
         end
      end
      // A commit on the same edge as clear keeps its flag.
      w_changed_nxt = (clear ? '0 : r_changed) | w_commit;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1       <= '0;
         r_sync2       <= '0;
         r_stable      <= '0;
         r_changed     <= '0;
         r_any_changed <= 1'b0;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_sync1       <= switches_raw;
         r_sync2       <= r_sync1;
         r_stable      <= w_stable_nxt;
         r_changed     <= w_changed_nxt;
         r_any_changed <= |w_changed_nxt;
         for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
      end
   end

   assign switches    = r_stable;
   assign changed     = r_changed;
   assign any_changed = r_any_changed;

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with STABLE_COUNT=4, CNT_BITS=3.
// One table of per-cycle vectors plus hand sequences for clear collision, reset and independent bits.
module tb_switch_debouncer;

   logic       clk;
   logic       reset;
   logic [7:0] switches_raw;
   logic       clear;
   logic [7:0] switches;
   logic [7:0] changed;
   logic       any_changed;

   int n_checks;
   int n_fail;

   typedef struct {
      logic [7:0] raw;
      logic       clr;
      logic       rst;
      logic [7:0] sw;
      logic [7:0] ch;
      logic       any;
   } vec_t;

   vec_t vecs[$];

   switch_debouncer #(
      .WIDTH        (8),
      .CNT_BITS     (3),
      .STABLE_COUNT (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .switches_raw (switches_raw),
      .clear        (clear),
      .switches     (switches),
      .changed      (changed),
      .any_changed  (any_changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_all(input string name, input logic [7:0] sw, input logic [7:0] ch,
                          input logic any);
      chk({name, " switches"}, switches, sw);
      chk({name, " changed"}, changed, ch);
      chk({name, " any_changed"}, {7'd0, any_changed}, {7'd0, any});
   endtask

   task automatic add(input logic [7:0] raw, input logic clr, input logic rst,
                      input logic [7:0] sw, input logic [7:0] ch, input logic any);
      vec_t v;
      v.raw = raw; v.clr = clr; v.rst = rst; v.sw = sw; v.ch = ch; v.any = any;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      reset = 1'b1; clear = 1'b0; switches_raw = 8'h00;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset = 1'b0; clear = 1'b0; switches_raw = 8'h00;

      // reset state
      add(8'h00, 0, 1, 8'h00, 8'h00, 0);
      // clean edge: commit on 6th edge after change
      for (int k = 0; k < 5; k++) add(8'h01, 0, 0, 8'h00, 8'h00, 0);
      add(8'h01, 0, 0, 8'h01, 8'h01, 1);
      add(8'h01, 1, 0, 8'h01, 8'h00, 0);
      // bounce on bit 3: high 3, low 1, then held high
      for (int k = 0; k < 3; k++) add(8'h09, 0, 0, 8'h01, 8'h00, 0);
      add(8'h01, 0, 0, 8'h01, 8'h00, 0);
      for (int k = 0; k < 5; k++) add(8'h09, 0, 0, 8'h01, 8'h00, 0);
      add(8'h09, 0, 0, 8'h09, 8'h08, 1);
      // bring all bits high
      for (int k = 0; k < 5; k++) add(8'hFF, 0, 0, 8'h09, 8'h08, 1);
      add(8'hFF, 0, 0, 8'hFF, 8'hFE, 1);
      add(8'hFF, 1, 0, 8'hFF, 8'h00, 0);
      // 3-cycle release glitch on bit 0 must be rejected
      for (int k = 0; k < 3; k++) add(8'hFE, 0, 0, 8'hFF, 8'h00, 0);
      for (int k = 0; k < 4; k++) add(8'hFF, 0, 0, 8'hFF, 8'h00, 0);
      // held release commits
      for (int k = 0; k < 5; k++) add(8'hFE, 0, 0, 8'hFF, 8'h00, 0);
      add(8'hFE, 0, 0, 8'hFE, 8'h01, 1);

      foreach (vecs[j]) begin
         switches_raw = vecs[j].raw;
         clear        = vecs[j].clr;
         reset        = vecs[j].rst;
         tick();
         chk_all($sformatf("vec%0d", j), vecs[j].sw, vecs[j].ch, vecs[j].any);
      end
      reset = 1'b0; clear = 1'b0;

      // clear collides with bit 0 commit while bit 5 flag is set
      do_reset();
      switches_raw = 8'h20;
      repeat (6) tick();
      chk_all("coll_setup", 8'h20, 8'h20, 1);
      switches_raw = 8'h21;
      repeat (5) tick();
      chk_all("coll_pre", 8'h20, 8'h20, 1);
      clear = 1'b1;
      tick();
      chk_all("coll_edge", 8'h21, 8'h01, 1);
      tick();
      chk_all("coll_clear2", 8'h21, 8'h00, 0);
      clear = 1'b0;

      // reset after 3 counted edges; reset edge would otherwise be the commit edge
      do_reset();
      switches_raw = 8'hA5;
      repeat (5) tick();
      chk_all("rst_mid_pre", 8'h00, 8'h00, 0);
      reset = 1'b1;
      tick();
      chk_all("rst_mid_edge", 8'h00, 8'h00, 0);
      reset = 1'b0;
      repeat (5) tick();
      chk_all("rst_mid_e5", 8'h00, 8'h00, 0);
      tick();
      chk_all("rst_mid_e6", 8'hA5, 8'hA5, 1);

      // independent bits: bit 1 at cycle 0, bit 6 at cycle 2
      do_reset();
      for (int e = 1; e <= 8; e++) begin
         logic [7:0] exp_v;
         switches_raw = (e >= 3) ? 8'h42 : 8'h02;
         tick();
         exp_v = (e >= 8) ? 8'h42 : (e >= 6) ? 8'h02 : 8'h00;
         chk_all($sformatf("indep_e%0d", e), exp_v, exp_v, exp_v != 8'h00);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
